nco_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer that sits directly upstream of an nco instance and drives its freq (tuning word) input.
- Steps the tuning word from f_start toward f_stop in f_step increments.
- Holds each word for a programmable dwell.
- Supports single, continuous-restart and triangle sweeps, giving stepped-chirp DAC stimulus for ADC loopback measurements.
- One instance per NCO channel inside the sub_top level.

---
 rtl/nco_pkg.sv | 24 ++
 rtl/sweep_step_calc.sv | 39 +++
 rtl/nco_sweep_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sweep controller.
//   FtwWDefault   : default tuning-word width (matches the nco freq input)
//   DwellWDefault : default dwell-length field width
//   sweep_mode_e  : sweep pattern selected on the start cycle
//   sweep_state_e : sweep sequencer states
package nco_pkg;

  localparam int unsigned FtwWDefault   = 28;
  localparam int unsigned DwellWDefault = 24;

  typedef enum logic [1:0] {
    SWEEP_SINGLE   = 2'd0,
    SWEEP_CONT     = 2'd1,
    SWEEP_TRI      = 2'd2,
    SWEEP_TRI_ONCE = 2'd3
  } sweep_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/sweep_step_calc.sv
// Combinational next-word calculation for the sweep controller.
//   cur_i    : current tuning word
//   step_i   : step magnitude (unsigned)
//   stop_i   : endpoint the sweep is heading toward
//   dir_up_i : 1 = stepping upward, 0 = downward
//   next_o   : cur +/- step, clamped to stop_i on overshoot or wrap
//   at_end_o : current word is already the endpoint (or the step is zero)
module sweep_step_calc
  import nco_pkg::*;
#(
  parameter int unsigned FTW_W = FtwWDefault
) (
  input  logic [FTW_W-1:0] cur_i,
  input  logic [FTW_W-1:0] step_i,
  input  logic [FTW_W-1:0] stop_i,
  input  logic             dir_up_i,
  output logic [FTW_W-1:0] next_o,
  output logic             at_end_o
);

  // One extra bit catches carry-out (up) and borrow (down).
  logic [FTW_W:0] sum;
  logic [FTW_W:0] diff;

  assign sum  = {1'b0, cur_i} + {1'b0, step_i};
  assign diff = {1'b0, cur_i} - {1'b0, step_i};

  always_comb begin
    next_o = stop_i;
    if (dir_up_i) begin
      if (!sum[FTW_W] && (sum[FTW_W-1:0] <= stop_i)) next_o = sum[FTW_W-1:0];
    end else begin
      if (!diff[FTW_W] && (diff[FTW_W-1:0] >= stop_i)) next_o = diff[FTW_W-1:0];
    end
  end

  assign at_end_o = (cur_i == stop_i) || (step_i == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer driving an nco tuning-word input.
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : sweep request (IDLE only) / stop (priority over start)
//   mode                : 0 single, 1 continuous restart, 2 triangle, 3 triangle once
//   f_start/stop/step   : sweep range and step, latched on the accepted start
//   dwell               : cycles per word (0 behaves as 1)
//   freq, freq_valid    : current tuning word and new-word pulse
//   busy, done          : sweep active / normal-completion pulse
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int unsigned FTW_W   = FtwWDefault,
  parameter int unsigned DWELL_W = DwellWDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [FTW_W-1:0]   f_start,
  input  logic [FTW_W-1:0]   f_stop,
  input  logic [FTW_W-1:0]   f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FTW_W-1:0]   freq,
  output logic               freq_valid,
  output logic               busy,
  output logic               done
);

  sweep_state_e       state_q, state_d;
  sweep_mode_e        mode_q, mode_d;
  logic [FTW_W-1:0]   freq_q, freq_d;
  logic               fv_q, fv_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [FTW_W-1:0]   fstart_q, fstart_d, fstop_q, fstop_d, fstep_q, fstep_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               dir_up_q, dir_up_d;
  // High while heading toward f_stop; cleared on the return leg of a triangle.
  logic               to_stop_q, to_stop_d;

  logic [FTW_W-1:0]   fwd_target, rev_target, fwd_next, rev_next;
  logic               fwd_up, fwd_at_end, rev_at_end, degenerate;
  logic [DWELL_W-1:0] dwell_rl, dwell_in_rl;

  assign fwd_target = to_stop_q ? fstop_q : fstart_q;
  assign rev_target = to_stop_q ? fstart_q : fstop_q;
  assign fwd_up     = to_stop_q ? dir_up_q : !dir_up_q;

  // Word that continues the current leg.
  sweep_step_calc #(.FTW_W(FTW_W)) u_fwd (
    .cur_i    (freq_q),
    .step_i   (fstep_q),
    .stop_i   (fwd_target),
    .dir_up_i (fwd_up),
    .next_o   (fwd_next),
    .at_end_o (fwd_at_end)
  );

  // Word that starts the opposite leg when a triangle turns around.
  sweep_step_calc #(.FTW_W(FTW_W)) u_rev (
    .cur_i    (freq_q),
    .step_i   (fstep_q),
    .stop_i   (rev_target),
    .dir_up_i (!fwd_up),
    .next_o   (rev_next),
    .at_end_o (rev_at_end)
  );

  // Both legs already at their endpoint only when step==0 or f_start==f_stop.
  assign degenerate = fwd_at_end && rev_at_end;

  // Counter counts max(dwell,1)-1 down to 0.
  assign dwell_rl    = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
  assign dwell_in_rl = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    freq_d    = freq_q;
    fv_d      = 1'b0;
    cnt_d     = cnt_q;
    fstart_d  = fstart_q;
    fstop_d   = fstop_q;
    fstep_d   = fstep_q;
    dwell_d   = dwell_q;
    dir_up_d  = dir_up_q;
    to_stop_d = to_stop_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          mode_d    = sweep_mode_e'(mode);
          fstart_d  = f_start;
          fstop_d   = f_stop;
          fstep_d   = f_step;
          dwell_d   = dwell;
          dir_up_d  = (f_stop >= f_start);
          to_stop_d = 1'b1;
          freq_d    = f_start;
          fv_d      = 1'b1;
          cnt_d     = dwell_in_rl;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          cnt_d = dwell_rl;
          if (degenerate) begin
            // Single-word sweep: finish or hold silently.
            if (mode_q == SWEEP_SINGLE || mode_q == SWEEP_TRI_ONCE) state_d = DONE;
          end else if (!fwd_at_end) begin
            freq_d = fwd_next;
            fv_d   = 1'b1;
          end else begin
            unique case (mode_q)
              SWEEP_SINGLE: state_d = DONE;
              SWEEP_CONT: begin
                freq_d = fstart_q;
                fv_d   = 1'b1;
              end
              SWEEP_TRI: begin
                freq_d    = rev_next;
                fv_d      = 1'b1;
                to_stop_d = !to_stop_q;
              end
              SWEEP_TRI_ONCE: begin
                if (to_stop_q) begin
                  freq_d    = rev_next;
                  fv_d      = 1'b1;
                  to_stop_d = 1'b0;
                end else begin
                  state_d = DONE;
                end
              end
              default: state_d = IDLE;
            endcase
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      fv_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= SWEEP_SINGLE;
      freq_q    <= '0;
      fv_q      <= 1'b0;
      cnt_q     <= '0;
      fstart_q  <= '0;
      fstop_q   <= '0;
      fstep_q   <= '0;
      dwell_q   <= '0;
      dir_up_q  <= 1'b0;
      to_stop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      freq_q    <= freq_d;
      fv_q      <= fv_d;
      cnt_q     <= cnt_d;
      fstart_q  <= fstart_d;
      fstop_q   <= fstop_d;
      fstep_q   <= fstep_d;
      dwell_q   <= dwell_d;
      dir_up_q  <= dir_up_d;
      to_stop_q <= to_stop_d;
    end
  end

  assign freq       = freq_q;
  assign freq_valid = fv_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: expected words are queued when a
// sweep is launched and popped by a monitor on every freq_valid pulse.
module tb_nco_sweep_ctrl;

  localparam int unsigned FW = 28;
  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [1:0]    mode;
  logic [FW-1:0] f_start, f_stop, f_step;
  logic [DW-1:0] dwell;
  logic [FW-1:0] freq;
  logic          freq_valid, busy, done;

  int n_vec = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int done_cnt = 0;
  logic [FW-1:0] exp_q[$];

  nco_sweep_ctrl #(.FTW_W(FW), .DWELL_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .f_start    (f_start),
    .f_stop     (f_stop),
    .f_step     (f_step),
    .dwell      (dwell),
    .freq       (freq),
    .freq_valid (freq_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every new word must match the next queued word.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (freq_valid) begin
        fv_cnt++;
        check_eq("sb_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_eq("sb_freq", freq, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [FW-1:0] fs, input logic [FW-1:0] fe,
                          input logic [FW-1:0] st, input logic [DW-1:0] dw);
    mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
    check_eq("done_seen", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int fv0;
    int pat[4];
    pat = '{0, 10, 20, 10};
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    repeat (3) tick();
    check_eq("rst_freq", freq, 0);
    check_eq("rst_fv", freq_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Mode 0 up sweep, with an ignored start (new config) while busy.
    fv0 = fv_cnt;
    exp_q.push_back(100); exp_q.push_back(110); exp_q.push_back(120); exp_q.push_back(130);
    do_start(2'd0, 100, 130, 10, 3);
    for (int c = 1; c <= 12; c++) begin
      check_eq("s1_freq", freq, 100 + 10 * ((c - 1) / 3));
      check_eq("s1_busy", busy, 1);
      check_eq("s1_done", done, 0);
      if (c == 3) begin
        start = 1'b1; f_start = 500; f_stop = 900; f_step = 1; mode = 2'd1; dwell = 7;
      end
      tick();
      start = 1'b0;
    end
    check_eq("s1_done_pulse", done, 1);
    check_eq("s1_busy_end", busy, 0);
    check_eq("s1_freq_hold", freq, 130);
    tick();
    check_eq("s1_done_clear", done, 0);
    check_eq("s1_fv_count", fv_cnt - fv0, 4);
    check_eq("s1_sb_empty", exp_q.size(), 0);

    // Abort at cycle 5.
    cyc = done_cnt;
    exp_q.push_back(100); exp_q.push_back(110);
    do_start(2'd0, 100, 130, 10, 3);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_busy", busy, 0);
    check_eq("ab_freq", freq, 110);
    check_eq("ab_done", done, 0);
    repeat (5) tick();
    check_eq("ab_no_done", done_cnt, cyc);
    check_eq("ab_sb_empty", exp_q.size(), 0);

    // Reset mid-sweep.
    exp_q.push_back(100); exp_q.push_back(110);
    do_start(2'd0, 100, 130, 10, 3);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_eq("mr_freq", freq, 0);
    check_eq("mr_fv", freq_valid, 0);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_done", done, 0);
    rst = 1'b0;
    tick();
    check_eq("mr_sb_empty", exp_q.size(), 0);

    // Downward sweep with clamp at f_stop.
    exp_q.push_back(130); exp_q.push_back(110); exp_q.push_back(100);
    do_start(2'd0, 130, 100, 20, 1);
    wait_done(20, cyc);
    check_eq("dn_cycles", cyc, 3);
    check_eq("dn_freq_hold", freq, 100);
    tick();
    check_eq("dn_sb_empty", exp_q.size(), 0);

    // Overflow clamp near the top of the range.
    exp_q.push_back(28'hFFFFFFB); exp_q.push_back(28'hFFFFFFF);
    do_start(2'd0, 28'hFFFFFFB, 28'hFFFFFFF, 10, 2);
    wait_done(20, cyc);
    check_eq("ov_cycles", cyc, 4);
    tick();
    check_eq("ov_sb_empty", exp_q.size(), 0);

    // dwell=0, step=0: one word for one cycle, then done.
    exp_q.push_back(55);
    do_start(2'd0, 55, 77, 0, 0);
    check_eq("dg_freq", freq, 55);
    check_eq("dg_busy", busy, 1);
    tick();
    check_eq("dg_done", done, 1);
    check_eq("dg_busy_end", busy, 0);
    tick();
    check_eq("dg_sb_empty", exp_q.size(), 0);

    // Mode 3: up then down, done after return to f_start.
    exp_q.push_back(0); exp_q.push_back(10); exp_q.push_back(20);
    exp_q.push_back(10); exp_q.push_back(0);
    do_start(2'd3, 0, 20, 10, 1);
    wait_done(30, cyc);
    check_eq("t1_cycles", cyc, 5);
    tick();
    check_eq("t1_sb_empty", exp_q.size(), 0);

    // Mode 2 triangle for 50 cycles, then abort.
    cyc = done_cnt;
    for (int k = 0; k < 25; k++) exp_q.push_back(FW'(pat[k % 4]));
    do_start(2'd2, 0, 20, 10, 2);
    for (int c = 1; c <= 50; c++) begin
      check_eq("tr_freq", freq, pat[((c - 1) / 2) % 4]);
      check_eq("tr_busy", busy, 1);
      if (c < 50) tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("tr_abort_busy", busy, 0);
    check_eq("tr_no_done", done_cnt, cyc);
    check_eq("tr_sb_empty", exp_q.size(), 0);

    // Mode 1 restart after the last word's dwell.
    exp_q.push_back(100); exp_q.push_back(110); exp_q.push_back(120);
    exp_q.push_back(130); exp_q.push_back(100); exp_q.push_back(110);
    do_start(2'd1, 100, 130, 10, 3);
    repeat (12) tick();
    check_eq("cr_restart_freq", freq, 100);
    check_eq("cr_restart_fv", freq_valid, 1);
    check_eq("cr_busy", busy, 1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("cr_abort_freq", freq, 110);
    check_eq("cr_sb_empty", exp_q.size(), 0);

    // Degenerate triangle: f_start == f_stop holds with no repeated pulses.
    fv0 = fv_cnt;
    exp_q.push_back(40);
    do_start(2'd2, 40, 40, 5, 1);
    repeat (10) tick();
    check_eq("dt_busy", busy, 1);
    check_eq("dt_freq", freq, 40);
    check_eq("dt_fv_count", fv_cnt - fv0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("dt_abort_busy", busy, 0);

    // Start and abort together in IDLE: abort wins.
    abort = 1'b1;
    do_start(2'd0, 7, 9, 1, 1);
    abort = 1'b0;
    check_eq("sa_busy", busy, 0);
    check_eq("sa_fv", freq_valid, 0);
    tick();

    check_eq("total_done", done_cnt, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
